// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, control-field encodings and the instruction classifier.
package mc_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int ALUOP_W = 3;

    typedef enum logic [2:0] {
        sIF   = 3'b000,
        sID   = 3'b001,
        sEXE  = 3'b010,
        sWB   = 3'b011,
        sMEM  = 3'b100,
        sHALT = 3'b111
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_OR  = 3'b011,
        ALU_AND = 3'b100,
        ALU_SLT = 3'b101,
        ALU_XOR = 3'b110
    } aluOpT;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JR     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [2:0] {
        C_UNDEF, C_ALU, C_BRANCH, C_JUMP, C_LOAD, C_STORE, C_HALT
    } instrClassT;

    typedef struct packed {
        instrClassT cls;
        logic       isRType;
        logic       extSel;
        logic       aluSrcA;
        logic       aluSrcB;
        aluOpT      aluOp;
    } instrInfoT;

    typedef struct packed {
        logic       pcWre;
        logic       irWre;
        logic       insMemRW;
        logic       extSel;
        logic       aluSrcA;
        logic       aluSrcB;
        logic [2:0] aluOp;
        logic       regWre;
        logic [1:0] regDst;
        logic       wrRegDSrc;
        logic       dbDataSrc;
        logic       mRD;
        logic       mWR;
        logic [1:0] pcSrc;
    } ctrlT;

    // funct only matters for opcode 000000; anything unrecognised is C_UNDEF.
    function automatic instrInfoT decodeInstr(input logic [5:0] opcode, input logic [5:0] funct);
        instrInfoT d;
        d = '{cls: C_UNDEF, isRType: 1'b0, extSel: 1'b0, aluSrcA: 1'b0,
              aluSrcB: 1'b0, aluOp: ALU_ADD};
        case (opcode)
            OP_RTYPE: begin
                d.isRType = 1'b1;
                d.cls     = C_ALU;
                case (funct)
                    F_SLL:   begin d.aluOp = ALU_SLL; d.aluSrcA = 1'b1; end
                    F_ADD:   d.aluOp = ALU_ADD;
                    F_SUB:   d.aluOp = ALU_SUB;
                    F_AND:   d.aluOp = ALU_AND;
                    F_OR:    d.aluOp = ALU_OR;
                    F_SLT:   d.aluOp = ALU_SLT;
                    F_JR:    d.cls   = C_JUMP;
                    default: d.cls   = C_UNDEF;
                endcase
            end
            OP_J, OP_JAL:   d.cls = C_JUMP;
            OP_BEQ, OP_BNE: begin d.cls = C_BRANCH; d.aluOp = ALU_SUB; d.extSel = 1'b1; end
            OP_BLTZ:        begin d.cls = C_BRANCH; d.aluOp = ALU_SUB; end
            OP_ADDIU:       begin d.cls = C_ALU; d.extSel = 1'b1; d.aluSrcB = 1'b1; end
            OP_SLTI:        begin d.cls = C_ALU; d.extSel = 1'b1; d.aluSrcB = 1'b1; d.aluOp = ALU_SLT; end
            OP_ANDI:        begin d.cls = C_ALU; d.aluSrcB = 1'b1; d.aluOp = ALU_AND; end
            OP_ORI:         begin d.cls = C_ALU; d.aluSrcB = 1'b1; d.aluOp = ALU_OR; end
            OP_XORI:        begin d.cls = C_ALU; d.aluSrcB = 1'b1; d.aluOp = ALU_XOR; end
            OP_LW:          begin d.cls = C_LOAD;  d.extSel = 1'b1; d.aluSrcB = 1'b1; end
            OP_SW:          begin d.cls = C_STORE; d.extSel = 1'b1; d.aluSrcB = 1'b1; end
            OP_HALT:        d.cls = C_HALT;
            default:        d.cls = C_UNDEF;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state plus instruction fields and
// ALU flags to the full set of datapath controls.
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
    input  stateT      state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       sign,
    output ctrlT       ctrl
);
    instrInfoT info;
    logic      active;
    logic      taken;

    always_comb begin
        ctrl   = '0;
        info   = decodeInstr(opcode, funct);
        active = (state == sID) || (state == sEXE) || (state == sMEM) || (state == sWB);
        taken  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero) ||
                 ((opcode == OP_BLTZ) && sign);

        if (state == sIF) begin
            ctrl.insMemRW = 1'b1;
            ctrl.irWre    = 1'b1;
        end

        // Operand selection stays stable for the whole life of the instruction.
        if (active) begin
            ctrl.extSel  = info.extSel;
            ctrl.aluSrcA = info.aluSrcA;
            ctrl.aluSrcB = info.aluSrcB;
            ctrl.aluOp   = info.aluOp;
        end

        case (state)
            sID: begin
                if (info.cls == C_JUMP) begin
                    ctrl.pcWre = 1'b1;
                    ctrl.pcSrc = (opcode == OP_RTYPE) ? PC_JR : PC_JUMP;
                    if (opcode == OP_JAL) begin
                        ctrl.regWre    = 1'b1;
                        ctrl.regDst    = RD_RA;
                        ctrl.wrRegDSrc = 1'b0;
                    end
                end else if (info.cls == C_UNDEF) begin
                    ctrl.pcWre = 1'b1;
                end
            end
            sEXE: begin
                if (info.cls == C_BRANCH) begin
                    ctrl.pcWre = 1'b1;
                    ctrl.pcSrc = taken ? PC_BRANCH : PC_NEXT;
                end
            end
            sMEM: begin
                ctrl.mRD = (info.cls == C_LOAD);
                if (info.cls == C_STORE) begin
                    ctrl.mWR   = 1'b1;
                    ctrl.pcWre = 1'b1;
                end
            end
            sWB: begin
                ctrl.pcWre     = 1'b1;
                ctrl.regWre    = 1'b1;
                ctrl.wrRegDSrc = 1'b1;
                ctrl.regDst    = info.isRType ? RD_RD : RD_RT;
                ctrl.dbDataSrc = (info.cls == C_LOAD);
                ctrl.mRD       = (info.cls == C_LOAD);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: state register and next-state sequencing;
// outputs come from mc_ctrl_decode and are held at zero while Reset is high.
import mc_ctrl_pkg::*;

module mc_control_unit #(
    parameter int STATE_W = mc_ctrl_pkg::STATE_W,
    parameter int ALUOP_W = mc_ctrl_pkg::ALUOP_W
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               sign,
    output logic [STATE_W-1:0] state,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               ExtSel,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegWre,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               mRD,
    output logic               mWR,
    output logic [1:0]         PCSrc
);
    stateT     stateQ, stateNext;
    instrInfoT info;
    ctrlT      decCtrl, ctrl;

    assign info = decodeInstr(opcode, funct);

    always_ff @(posedge CLK) begin
        if (Reset) stateQ <= sIF;
        else       stateQ <= stateNext;
    end

    always_comb begin
        stateNext = sIF;
        case (stateQ)
            sIF:  stateNext = sID;
            sID: begin
                case (info.cls)
                    C_JUMP, C_UNDEF: stateNext = sIF;
                    C_HALT:          stateNext = sHALT;
                    default:         stateNext = sEXE;
                endcase
            end
            sEXE: begin
                case (info.cls)
                    C_BRANCH:        stateNext = sIF;
                    C_LOAD, C_STORE: stateNext = sMEM;
                    default:         stateNext = sWB;
                endcase
            end
            sMEM:    stateNext = (info.cls == C_STORE) ? sIF : sWB;
            sWB:     stateNext = sIF;
            sHALT:   stateNext = sHALT;
            default: stateNext = sIF;
        endcase
    end

    mc_ctrl_decode uDecode (
        .state  (stateQ),
        .opcode (opcode),
        .funct  (funct),
        .zero   (zero),
        .sign   (sign),
        .ctrl   (decCtrl)
    );

    // Reset kills the in-flight instruction immediately, not just at the edge.
    assign ctrl      = Reset ? '0 : decCtrl;
    assign state     = Reset ? '0 : STATE_W'(stateQ);
    assign PCWre     = ctrl.pcWre;
    assign IRWre     = ctrl.irWre;
    assign InsMemRW  = ctrl.insMemRW;
    assign ExtSel    = ctrl.extSel;
    assign ALUSrcA   = ctrl.aluSrcA;
    assign ALUSrcB   = ctrl.aluSrcB;
    assign ALUOp     = ALUOP_W'(ctrl.aluOp);
    assign RegWre    = ctrl.regWre;
    assign RegDst    = ctrl.regDst;
    assign WrRegDSrc = ctrl.wrRegDSrc;
    assign DBDataSrc = ctrl.dbDataSrc;
    assign mRD       = ctrl.mRD;
    assign mWR       = ctrl.mWR;
    assign PCSrc     = ctrl.pcSrc;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction state paths and control values
// derived from instruction-level rules, checked every cycle on the falling edge.
module tb_mc_control_unit;
    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode, funct;
    logic       zero, sign;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc;

    int nCmp = 0;
    int nErr = 0;

    logic        expValid = 1'b0;
    logic [2:0]  expState;
    logic [17:0] expCtrl;
    logic [17:0] dutCtrl;

    mc_control_unit dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero), .sign(sign),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
    );

    always #5 CLK = ~CLK;

    assign dutCtrl = {PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegWre,
                      RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s op=%b fn=%b: got %0h want %0h (t=%0t)", name, opcode, funct, act, exp, $time);
        end
    endtask

    // Controls for one cycle of an instruction, from the per-instruction rules.
    function automatic logic [17:0] modelCtrl(input logic [5:0] op, input logic [5:0] fn,
                                              input logic z, input logic s,
                                              input logic [2:0] st, input logic last);
        logic       isR, sll, jr, ld, stw, br, jal, jmp, act;
        logic [2:0] aop;
        logic [1:0] pcs, rd;
        logic       ext, sa, sb, rw, wd, dbs, mrd, mwr;
        isR = (op == 6'h00);
        sll = isR && (fn == 6'h00);
        jr  = isR && (fn == 6'h08);
        ld  = (op == 6'h23);
        stw = (op == 6'h2b);
        br  = (op == 6'h01) || (op == 6'h04) || (op == 6'h05);
        jal = (op == 6'h03);
        jmp = (op == 6'h02) || jal || jr;
        act = (st == 3'd1) || (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
        aop = 3'd0;
        if (isR) begin
            case (fn)
                6'h00: aop = 3'd2;
                6'h22: aop = 3'd1;
                6'h24: aop = 3'd4;
                6'h25: aop = 3'd3;
                6'h2a: aop = 3'd5;
                default: aop = 3'd0;
            endcase
        end else begin
            case (op)
                6'h01, 6'h04, 6'h05: aop = 3'd1;
                6'h0d: aop = 3'd3;
                6'h0c: aop = 3'd4;
                6'h0a: aop = 3'd5;
                6'h0e: aop = 3'd6;
                default: aop = 3'd0;
            endcase
        end
        if (!act) aop = 3'd0;
        ext = act && (op inside {6'h09, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05});
        sa  = act && sll;
        sb  = act && (op inside {6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b});
        pcs = 2'd0;
        if (last && jmp) pcs = jr ? 2'd2 : 2'd3;
        if (br && st == 3'd2)
            pcs = (((op == 6'h04) && z) || ((op == 6'h05) && !z) || ((op == 6'h01) && s)) ? 2'd1 : 2'd0;
        rw  = (jal && st == 3'd1) || (st == 3'd3);
        rd  = (st == 3'd3) ? (isR ? 2'd2 : 2'd1) : 2'd0;
        wd  = (st == 3'd3);
        dbs = ld && (st == 3'd3);
        mrd = ld && ((st == 3'd4) || (st == 3'd3));
        mwr = stw && (st == 3'd4);
        return {last, (st == 3'd0), (st == 3'd0), ext, sa, sb, aop, rw, rd, wd, dbs, mrd, mwr, pcs};
    endfunction

    always @(negedge CLK) begin
        if (expValid) begin
            chk("state", 32'(state), 32'(expState));
            chk($sformatf("ctrl@s%0d", expState), 32'(dutCtrl), 32'(expCtrl));
        end
    end

    // Runs one instruction from IF; abortAt>=0 asserts Reset on that cycle.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic s,
                            input int abortAt, output logic [23:0] trace, output int len);
        logic [2:0] path [12];
        int         n;
        logic       isR, aluR, aluI, br, ld, stw, hlt;
        isR  = (op == 6'h00);
        aluR = isR && (fn inside {6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
        aluI = op inside {6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e};
        br   = op inside {6'h01, 6'h04, 6'h05};
        ld   = (op == 6'h23);
        stw  = (op == 6'h2b);
        hlt  = (op == 6'h3f);
        for (int k = 0; k < 12; k++) path[k] = 3'd0;
        path[1] = 3'd1;
        n = 2;
        if (hlt)              begin for (int k = 2; k < 12; k++) path[k] = 3'd7; n = 12; end
        else if (br)          begin path[2] = 3'd2; n = 3; end
        else if (stw)         begin path[2] = 3'd2; path[3] = 3'd4; n = 4; end
        else if (ld)          begin path[2] = 3'd2; path[3] = 3'd4; path[4] = 3'd3; n = 5; end
        else if (aluR || aluI) begin path[2] = 3'd2; path[3] = 3'd3; n = 4; end
        opcode = op; funct = fn; zero = z; sign = s;
        trace = '0; len = 0;
        for (int i = 0; i < n; i++) begin
            if (i == abortAt) begin
                Reset = 1'b1; expState = 3'd0; expCtrl = '0;
                @(negedge CLK);
                @(posedge CLK); #1;
                Reset = 1'b0;
                return;
            end
            expState = path[i];
            expCtrl  = modelCtrl(op, fn, z, s, path[i], !hlt && (i == n - 1));
            expValid = 1'b1;
            @(negedge CLK);
            trace = {trace[20:0], state};
            len++;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] tr;
        int          ln;
        Reset = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0; sign = 1'b0;
        expState = 3'd0; expCtrl = '0; expValid = 1'b1;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;

        runInstr(6'h09, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // addiu
        chk("addiu-trace", 32'(tr), 32'h053);
        chk("addiu-len", 32'(ln), 32'd4);
        runInstr(6'h0c, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // andi
        runInstr(6'h0d, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // ori
        runInstr(6'h0e, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // xori
        runInstr(6'h0a, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // slti
        runInstr(6'h00, 6'h20, 1'b0, 1'b0, -1, tr, ln);   // add
        runInstr(6'h00, 6'h22, 1'b0, 1'b0, -1, tr, ln);   // sub
        runInstr(6'h00, 6'h24, 1'b0, 1'b0, -1, tr, ln);   // and
        runInstr(6'h00, 6'h25, 1'b0, 1'b0, -1, tr, ln);   // or
        runInstr(6'h00, 6'h2a, 1'b0, 1'b0, -1, tr, ln);   // slt
        runInstr(6'h00, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // sll / nop
        chk("sll-len", 32'(ln), 32'd4);
        runInstr(6'h23, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // lw
        chk("lw-trace", 32'(tr), 32'h2a3);
        chk("lw-len", 32'(ln), 32'd5);
        runInstr(6'h2b, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // sw
        chk("sw-trace", 32'(tr), 32'h054);
        runInstr(6'h04, 6'h00, 1'b1, 1'b0, -1, tr, ln);   // beq taken
        chk("beq-trace", 32'(tr), 32'h00a);
        chk("beq-len", 32'(ln), 32'd3);
        runInstr(6'h04, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // beq not taken
        runInstr(6'h05, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // bne taken
        runInstr(6'h05, 6'h00, 1'b1, 1'b0, -1, tr, ln);   // bne not taken
        runInstr(6'h01, 6'h00, 1'b0, 1'b1, -1, tr, ln);   // bltz taken
        runInstr(6'h01, 6'h00, 1'b1, 1'b0, -1, tr, ln);   // bltz not taken
        runInstr(6'h02, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // j
        runInstr(6'h03, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // jal
        chk("jal-trace", 32'(tr), 32'h001);
        chk("jal-len", 32'(ln), 32'd2);
        runInstr(6'h00, 6'h08, 1'b0, 1'b0, -1, tr, ln);   // jr
        runInstr(6'h10, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // undefined opcode
        runInstr(6'h00, 6'h3f, 1'b0, 1'b0, -1, tr, ln);   // undefined funct
        chk("undef-len", 32'(ln), 32'd2);
        runInstr(6'h23, 6'h00, 1'b0, 1'b0, 3, tr, ln);    // lw aborted in sMEM
        runInstr(6'h09, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // restarts cleanly from sIF
        chk("post-abort-trace", 32'(tr), 32'h053);
        runInstr(6'h3f, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // halt
        Reset = 1'b1; expState = 3'd0; expCtrl = '0;
        @(negedge CLK);
        @(posedge CLK); #1;
        Reset = 1'b0;
        runInstr(6'h2b, 6'h00, 1'b0, 1'b0, -1, tr, ln);   // sw after halt
        chk("post-halt-trace", 32'(tr), 32'h054);
        expValid = 1'b0;
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
